// File: rtl/pe_alu_pipe.sv
// pe_alu_pipe: elastic 1- or 2-stage PE ALU; define PE_ALU_SAT_EN for signed saturating ADD/SUB/MAC
module pe_alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            ALU_func,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  carry_out,
  output logic                  zero_out,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int W = DATA_WIDTH;
`ifdef PE_ALU_SAT_EN
  localparam int PW = 2 * W;
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  logic [2*W:0] mac_w;
`else
  localparam int PW = W;
`endif
  typedef struct packed {
    logic [2:0]    op;
    logic [W:0]    add;
    logic [W:0]    sub;
    logic [PW-1:0] prod;
    logic [W-1:0]  c;
    logic [W-1:0]  lg;
  } mid_t;
  mid_t         mid_d, fin_src;
  logic [W-1:0] add_r, sub_r, mac_r, res_d, data_q;
  logic         add_c, sub_c, mac_c, carry_d, carry_q, zero_q, out_valid_q;
  logic         ready_o, src_valid;
  // front half: sums with carry/borrow, product, addend and logic/select result
  always_comb begin
    mid_d.op   = ALU_func;
`ifdef PE_ALU_SAT_EN
    mid_d.add  = {data_in1[W-1], data_in1} + {data_in2[W-1], data_in2};
    mid_d.sub  = {data_in1[W-1], data_in1} - {data_in2[W-1], data_in2};
    mid_d.prod = {{W{data_in1[W-1]}}, data_in1} * {{W{data_in2[W-1]}}, data_in2};
`else
    mid_d.add  = {1'b0, data_in1} + {1'b0, data_in2};
    mid_d.sub  = {1'b0, data_in1} - {1'b0, data_in2};
    mid_d.prod = data_in1 * data_in2;
`endif
    mid_d.c    = data_in3;
    mid_d.lg   = ALU_func == 3'd4 ? data_in1 & data_in2 :
                 ALU_func == 3'd5 ? data_in1 | data_in2 :
                 ALU_func == 3'd6 ? data_in1 ^ data_in2 :
                 data_in3[0] ? data_in2 : data_in1;
  end
  // back half: MAC add, saturation (if enabled) and final op mux
  always_comb begin
`ifdef PE_ALU_SAT_EN
    mac_w = {fin_src.prod[PW-1], fin_src.prod} + {{(W+1){fin_src.c[W-1]}}, fin_src.c};
    add_c = fin_src.add[W] ^ fin_src.add[W-1];
    sub_c = fin_src.sub[W] ^ fin_src.sub[W-1];
    mac_c = !((&mac_w[2*W:W-1]) || !(|mac_w[2*W:W-1]));
    add_r = add_c ? (fin_src.add[W] ? MIN_V : MAX_V) : fin_src.add[W-1:0];
    sub_r = sub_c ? (fin_src.sub[W] ? MIN_V : MAX_V) : fin_src.sub[W-1:0];
    mac_r = mac_c ? (mac_w[2*W] ? MIN_V : MAX_V) : mac_w[W-1:0];
`else
    add_c = fin_src.add[W];
    sub_c = fin_src.sub[W];
    mac_c = 1'b0;
    add_r = fin_src.add[W-1:0];
    sub_r = fin_src.sub[W-1:0];
    mac_r = fin_src.prod + fin_src.c;
`endif
    res_d   = fin_src.op == 3'd0 ? add_r :
              fin_src.op == 3'd1 ? sub_r :
              fin_src.op == 3'd2 ? fin_src.prod[W-1:0] :
              fin_src.op == 3'd3 ? mac_r : fin_src.lg;
    carry_d = fin_src.op == 3'd0 ? add_c :
              fin_src.op == 3'd1 ? sub_c :
              fin_src.op == 3'd3 ? mac_c : 1'b0;
  end
  assign ready_o = !out_valid_q || out_ready;
  if (PIPE_DEPTH == 2) begin : g_two
    logic s1_valid_q;
    mid_t mid_q;
    // first stage register: refills whenever the output stage can take its token
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        mid_q      <= '0;
      end else if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) mid_q <= mid_d;
      end
    end
    assign in_ready  = !s1_valid_q || ready_o;
    assign src_valid = s1_valid_q;
    assign fin_src   = mid_q;
  end else if (PIPE_DEPTH == 1) begin : g_one
    assign in_ready  = ready_o;
    assign src_valid = in_valid;
    assign fin_src   = mid_d;
  end else begin : g_bad
    $error("pe_alu_pipe: PIPE_DEPTH must be 1 or 2");
  end
  // output stage: holds result and flags steady while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else if (ready_o) begin
      out_valid_q <= src_valid;
      if (src_valid) begin
        data_q  <= res_d;
        carry_q <= carry_d;
        zero_q  <= res_d == '0;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;
endmodule

// File: tb/tb_pe_alu_pipe.sv
// tb_pe_alu_pipe: scoreboard bench for pe_alu_pipe (PIPE_DEPTH=2, 32-bit; honours PE_ALU_SAT_EN)
module tb_pe_alu_pipe;
  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        z;
  } res_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ALU_func = '0;
  logic [31:0] data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, carry_out, zero_out, out_valid;
  logic [31:0] data_out;
  int          ntests = 0, nfail = 0;
  res_t        sb[$];
  logic        acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [33:0] prev_out;

  pe_alu_pipe #(.DATA_WIDTH(32), .PIPE_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_func(ALU_func),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .carry_out(carry_out), .zero_out(zero_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic res_t sat(input longint v);
    res_t r;
    r.c = v > 64'sd2147483647 || v < -64'sd2147483648;
    r.d = v > 64'sd2147483647 ? 32'h7FFF_FFFF : v < -64'sd2147483648 ? 32'h8000_0000 : v[31:0];
    r.z = 1'b0;
    return r;
  endfunction

  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, b, c);
    res_t r;
    logic [32:0] s;
    r.c = 1'b0;
    r.d = '0;
    case (op)
`ifdef PE_ALU_SAT_EN
      3'd0: r = sat(longint'($signed(a)) + longint'($signed(b)));
      3'd1: r = sat(longint'($signed(a)) - longint'($signed(b)));
      3'd3: r = sat(longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c)));
`else
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r.d = s[31:0]; r.c = s[32]; end
      3'd1: begin r.d = a - b; r.c = a < b; end
      3'd3: r.d = a * b + c;
`endif
      3'd2: r.d = a * b;
      3'd4: r.d = a & b;
      3'd5: r.d = a | b;
      3'd6: r.d = a ^ b;
      default: r.d = c[0] ? b : a;
    endcase
    r.z = r.d == 32'd0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample handshakes at negedge, score the drain, push accepted token, return at posedge+1
  task automatic tick();
    res_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("data", {32'd0, data_out}, {32'd0, e.d});
        chk("carry", {63'd0, carry_out}, {63'd0, e.c});
        chk("zero", {63'd0, zero_out}, {63'd0, e.z});
      end
    end
    if (out_valid && !out_ready) begin
      if (stall_prev) chk("stall_stable", {30'd0, data_out, carry_out, zero_out}, {30'd0, prev_out});
      stall_prev = 1'b1;
      prev_out = {data_out, carry_out, zero_out};
    end else stall_prev = 1'b0;
    if (acc) sb.push_back(model(ALU_func, data_in1, data_in2, data_in3));
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] op, input logic [31:0] a, b, c);
    in_valid = 1'b1;
    ALU_func = op;
    data_in1 = a;
    data_in2 = b;
    data_in3 = c;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [2:0]  s_op [8] = '{3'd2, 3'd3, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [31:0] s_a  [8] = '{32'd3, 32'd3, 32'd2, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h11, 32'd10};
  logic [31:0] s_b  [8] = '{32'd5, 32'd5, 32'd5, 32'h0FF0, 32'h0FF0, 32'h0FF0, 32'h22, 32'd20};
  logic [31:0] s_c  [8] = '{32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, data_out}, 64'd0);
    chk("rst_carry", {63'd0, carry_out}, 64'd0);
    chk("rst_zero", {63'd0, zero_out}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    put(3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    chk("add_accept", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
    chk("add_lat1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("add_lat2_valid", {63'd0, out_valid}, 64'd1);
    chk("add_lat2_data", {32'd0, data_out}, 64'd0);
`ifdef PE_ALU_SAT_EN
    chk("add_lat2_carry", {63'd0, carry_out}, 64'd0);
`else
    chk("add_lat2_carry", {63'd0, carry_out}, 64'd1);
`endif
    chk("add_lat2_zero", {63'd0, zero_out}, 64'd1);
    drain();

    for (int i = 0; i < 8; i++) begin
      put(s_op[i], s_a[i], s_b[i], s_c[i]);
      tick();
      chk("stream_accept", {63'd0, acc}, 64'd1);
    end
    drain();

    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      put(s_op[n], s_a[n], s_b[n], s_c[n]);
      tick();
      if (acc) n++;
    end
    chk("hold_accepted", 64'(n), 64'd2);
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    drain();

    out_ready = 1'b0;
    put(3'd2, 32'd6, 32'd7, 32'd0);
    tick();
    put(3'd6, 32'hAAAA_5555, 32'h1234_5678, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_async_data", {32'd0, data_out}, 64'd0);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", {63'd0, out_valid}, 64'd0);
    end

    put(3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
    tick();
    put(3'd1, 32'h8000_0000, 32'd1, 32'd0);
    tick();
    put(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd5);
    tick();
    drain();

    acc = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (acc || !in_valid) begin
        in_valid = $urandom_range(0, 3) != 0;
        ALU_func = 3'($urandom_range(0, 7));
        data_in1 = $urandom;
        data_in2 = (i % 5 == 0) ? data_in1 : $urandom;
        data_in3 = $urandom;
      end
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
